// File: rtl/mcycle_unit.sv
// mcycle_unit
// Iterative RV32M multiply/divide unit that sits beside the ALU in the execute stage.
// It runs a shift-add multiply or a restoring divide, one step per cycle, for WIDTH cycles.
//
// Ports
//   CLK        rising-edge clock
//   RESET      asynchronous, active-high reset; aborts any operation in flight
//   Start      operation request, held high by the stalled pipeline
//   MCycleOp   00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div
//   Operand1   multiplicand / dividend
//   Operand2   multiplier / divisor
//   Result1    product low half / quotient
//   Result2    product high half / remainder
//   Busy       stall request to the pipeline
//   dbg_state  current FSM state (0 IDLE, 1 COMPUTE, 2 DONE)
//
// Handshake: an operation is accepted on any rising edge where the state is IDLE
// and Start=1. In IDLE, Busy mirrors Start combinationally so the issuing cycle
// stalls. Busy stays high through COMPUTE. It drops in DONE, which is the single
// cycle in which the results are new. Start is ignored in DONE because the
// stalled instruction still holds it high. Result1/Result2 hold their value until
// the next completion.
module mcycle_unit #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             Start,
   input  logic [1:0]       MCycleOp,
   input  logic [WIDTH-1:0] Operand1,
   input  logic [WIDTH-1:0] Operand2,
   output logic [WIDTH-1:0] Result1,
   output logic [WIDTH-1:0] Result2,
   output logic             Busy,
   output logic [1:0]       dbg_state
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [1:0]         op_q;
   logic               sign1_q, sign2_q;
   logic               divz_q;
   logic [WIDTH-1:0]   raw1_q;     // dividend as issued, returned on divide by zero
   logic [WIDTH-1:0]   mag_q;      // multiplicand magnitude or divisor magnitude
   logic [2*WIDTH-1:0] acc_q;      // multiply accumulator, multiplier in the low half
   logic [WIDTH:0]     rem_q;      // restoring-divide partial remainder
   logic [WIDTH-1:0]   quo_q;      // dividend bits shifting out, quotient bits shifting in
   logic [CW-1:0]      cnt_q;

   logic               last_iter;
   logic               is_signed_in, s1_in, s2_in;
   logic [WIDTH-1:0]   m1_in, m2_in;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] acc_step;
   logic [WIDTH:0]     rem_sh, rem_step;
   logic [WIDTH-1:0]   quo_sh, quo_step;
   logic               ge;

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   q_fix, r_fix;
   logic [WIDTH-1:0]   res1_fin, res2_fin;

   assign dbg_state = state;
   assign last_iter = (cnt_q == CW'(WIDTH - 1));

   // Operand capture. The absolute value of -2^(WIDTH-1) wraps to itself. Read as
   // unsigned, that is the correct magnitude, so overflow cases need no special case.
   assign is_signed_in = ~MCycleOp[0];
   assign s1_in        = is_signed_in & Operand1[WIDTH-1];
   assign s2_in        = is_signed_in & Operand2[WIDTH-1];
   assign m1_in        = s1_in ? -Operand1 : Operand1;
   assign m2_in        = s2_in ? -Operand2 : Operand2;

   // Shift-add step. The carry out of the upper-half add becomes the new MSB.
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
   assign acc_step = {mul_sum, acc_q[WIDTH-1:1]};

   // Restoring divide step. The remainder stays below the divisor, so the shifted
   // value fits in WIDTH+1 bits. Any bit left in the top position forces a subtract.
   assign rem_sh   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
   assign quo_sh   = {quo_q[WIDTH-2:0], 1'b0};
   assign ge       = rem_q[WIDTH] | (rem_sh >= {1'b0, mag_q});
   assign rem_step = ge ? (rem_sh - {1'b0, mag_q}) : rem_sh;
   assign quo_step = quo_sh | {{(WIDTH-1){1'b0}}, ge};

   // Sign fix-up applied to the final iteration's output
   assign prod_fix = (~op_q[0] & (sign1_q ^ sign2_q)) ? -acc_step : acc_step;
   assign q_fix    = (~op_q[0] & (sign1_q ^ sign2_q)) ? -quo_step : quo_step;
   assign r_fix    = (~op_q[0] & sign1_q) ? -rem_step[WIDTH-1:0] : rem_step[WIDTH-1:0];

   always_comb begin
      res1_fin = prod_fix[WIDTH-1:0];
      res2_fin = prod_fix[2*WIDTH-1:WIDTH];
      if (op_q[1]) begin
         if (divz_q) begin
            res1_fin = '1;
            res2_fin = raw1_q;
         end else begin
            res1_fin = q_fix;
            res2_fin = r_fix;
         end
      end
   end

   // FSM
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      Busy      = 1'b0;
      case (state)
         IDLE: begin
            Busy = Start;
            if (Start) state_nxt = COMPUTE;
         end
         COMPUTE: begin
            Busy = 1'b1;
            if (last_iter) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         op_q    <= '0;
         sign1_q <= 1'b0;
         sign2_q <= 1'b0;
         divz_q  <= 1'b0;
         raw1_q  <= '0;
         mag_q   <= '0;
         acc_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         Result1 <= '0;
         Result2 <= '0;
      end else begin
         if (state == IDLE && Start) begin
            op_q    <= MCycleOp;
            sign1_q <= s1_in;
            sign2_q <= s2_in;
            divz_q  <= (Operand2 == '0);
            raw1_q  <= Operand1;
            mag_q   <= MCycleOp[1] ? m2_in : m1_in;
            acc_q   <= {{WIDTH{1'b0}}, m2_in};
            rem_q   <= '0;
            quo_q   <= m1_in;
            cnt_q   <= '0;
         end else if (state == COMPUTE) begin
            acc_q <= acc_step;
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt_q <= cnt_q + CW'(1);
            if (last_iter) begin
               Result1 <= res1_fin;
               Result2 <= res2_fin;
            end
         end
      end
   end

endmodule

// File: tb/tb_mcycle_unit.sv
// tb_mcycle_unit
// Testbench for mcycle_unit.
// A driver issues operations and pushes the expected {Result2, Result1} into exp_q.
// A monitor pops exp_q and compares whenever the unit reports DONE.
// While an operation is computing, the monitor also checks that the results hold their last value.
module tb_mcycle_unit;

   localparam int W = 32;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          Start;
   logic [1:0]    MCycleOp;
   logic [W-1:0]  Operand1, Operand2;
   logic [W-1:0]  Result1, Result2;
   logic          Busy;
   logic [1:0]    dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   logic [2*W-1:0] exp_q[$];
   logic [2*W-1:0] last_exp = '0;

   mcycle_unit #(.WIDTH(W)) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .Start    (Start),
      .MCycleOp (MCycleOp),
      .Operand1 (Operand1),
      .Operand2 (Operand2),
      .Result1  (Result1),
      .Result2  (Result2),
      .Busy     (Busy),
      .dbg_state(dbg_state)
   );

   // Clock
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model: RV32M results from plain integer arithmetic, packed as {Result2, Result1}
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint     sa, sb;
      logic [31:0] q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'd0: return 64'(sa * sb);
         2'd1: return {32'd0, a} * {32'd0, b};
         default: begin
            if (b == 32'd0) begin
               q = 32'hFFFF_FFFF;
               r = a;
            end else if (op == 2'd2) begin
               q = 32'(sa / sb);
               r = 32'(sa % sb);
            end else begin
               q = a / b;
               r = a % b;
            end
            return {r, q};
         end
      endcase
   endfunction

   // Monitor / scoreboard
   always @(negedge CLK) begin
      if (RESET) begin
         last_exp = '0;
      end else if (dbg_state == 2'd2) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_done: result %h with empty queue, expected none",
                     {Result2, Result1});
         end else begin
            last_exp = exp_q.pop_front();
            check("result", {Result2, Result1}, last_exp);
         end
      end else if (dbg_state == 2'd1) begin
         check("hold_in_compute", {Result2, Result1}, last_exp);
      end
   end

   // Driver: issue one operation and keep Start high until Busy falls.
   // With drop=0, Start stays high and the next call issues back-to-back in cycle W+2.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit drop);
      int n;
      @(negedge CLK);
      Start    = 1'b1;
      MCycleOp = op;
      Operand1 = a;
      Operand2 = b;
      exp_q.push_back(exp);
      #1;
      n = 0;
      while (Busy && n < 100) begin
         n++;
         @(negedge CLK);
         if (n == 1) begin
            MCycleOp = 2'($urandom);
            Operand1 = $urandom;
            Operand2 = $urandom;
         end
         #1;
      end
      check("busy_cycles", n, W + 1);
      if (drop) begin
         @(negedge CLK);
         Start = 1'b0;
         #1;
         check("busy_idle", Busy, 0);
         check("state_idle", dbg_state, 0);
      end
   endtask

   initial begin
      logic [1:0]  op;
      logic [31:0] a, b;
      RESET    = 1'b1;
      Start    = 1'b0;
      MCycleOp = 2'd0;
      Operand1 = '0;
      Operand2 = '0;
      #2;
      check("reset_r1", Result1, 0);
      check("reset_r2", Result2, 0);
      check("reset_state", dbg_state, 0);
      check("reset_busy_lo", Busy, 0);
      Start = 1'b1;
      #1;
      check("reset_busy_follows", Busy, 1);
      Start = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b0;

      // Directed vectors with hand-derived expectations
      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 1);
      run_op(2'd0, 32'hFFFF_FFF9, 32'd3,         {32'hFFFF_FFFF, 32'hFFFF_FFEB}, 0);
      run_op(2'd0, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0000_0000}, 1);
      run_op(2'd2, 32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1);
      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 0);
      run_op(2'd2, 32'hFFFF_FFFB, 32'd0,         {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1);
      run_op(2'd3, 32'd100,       32'd0,         {32'd100,       32'hFFFF_FFFF}, 1);

      // Reset in the middle of COMPUTE. No expected result is queued for this operation.
      @(negedge CLK);
      Start    = 1'b1;
      MCycleOp = 2'd1;
      Operand1 = 32'h1234_5678;
      Operand2 = 32'h9ABC_DEF0;
      repeat (11) @(negedge CLK);
      #2;
      RESET = 1'b1;
      #1;
      check("abort_state", dbg_state, 0);
      check("abort_r1", Result1, 0);
      check("abort_r2", Result2, 0);
      Start = 1'b0;
      #1;
      check("abort_busy", Busy, 0);
      @(negedge CLK);
      #2;
      RESET = 1'b0;
      run_op(2'd3, 32'd1000, 32'd7, {32'd6, 32'd142}, 1);

      // Randomized operations against the model
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         case ($urandom_range(0, 4))
            0:       b = $urandom_range(0, 15);
            1:       b = 32'd0;
            2:       b = 32'hFFFF_FFFF;
            3:       begin a = 32'h8000_0000; b = $urandom; end
            default: b = $urandom;
         endcase
         run_op(op, a, b, model(op, a, b), 1'($urandom_range(0, 1)));
      end

      @(negedge CLK);
      Start = 1'b0;
      repeat (3) @(negedge CLK);
      check("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
